// File: rtl/led_seq_pkg.sv
// Shared mode encodings and next-pattern computation for the LED sequencer.
package led_seq_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest supported pattern; narrower patterns live in the low bits.
  localparam int unsigned PAT_MAX_W = 32;

  typedef struct packed {
    logic                 dir;
    logic [PAT_MAX_W-1:0] pat;
  } pat_step_t;

  // Next pattern and direction for an n-bit pattern, 2 <= n <= PAT_MAX_W.
  function automatic pat_step_t next_pattern(
    input logic [1:0]           mode,
    input logic [PAT_MAX_W-1:0] pat,
    input logic                 dir,
    input int unsigned          n
  );
    logic [PAT_MAX_W-1:0] mask;
    logic [PAT_MAX_W-1:0] msb;
    pat_step_t            res;
    mask    = (n >= PAT_MAX_W) ? '1 : ((PAT_MAX_W'(1) << n) - PAT_MAX_W'(1));
    msb     = PAT_MAX_W'(1) << (n - 1);
    res.dir = dir;
    res.pat = pat;
    case (mode)
      MODE_ROT_L: res.pat = ((pat << 1) | (pat >> (n - 1))) & mask;
      MODE_ROT_R: res.pat = ((pat >> 1) | ((pat & PAT_MAX_W'(1)) << (n - 1))) & mask;
      MODE_BOUNCE: begin
        if (dir == DIR_UP) begin
          res.pat = (pat << 1) & mask;
          if (res.pat == msb) res.dir = DIR_DOWN;
        end else begin
          res.pat = pat >> 1;
          if (res.pat == PAT_MAX_W'(1)) res.dir = DIR_UP;
        end
      end
      default: res.pat = (pat + PAT_MAX_W'(1)) & mask;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/led_sequencer_pwm.sv
// Free-running PWM counter and duty comparator producing the LED brightness gate.
module led_pwm
  import led_seq_pkg::*;
#(
  parameter int unsigned PWM_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [PWM_W-1:0] duty,
  output logic             gate
);

  logic [PWM_W-1:0] pwm_cnt;

  // Counter advances only while enabled; all-ones duty keeps the gate fully on.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pwm_cnt <= '0;
      gate    <= 1'b0;
    end else begin
      if (enable) pwm_cnt <= pwm_cnt + PWM_W'(1);
      gate <= (pwm_cnt < duty) || (&duty);
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: period-timed pattern steps in four modes, PWM-dimmed output.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned N_LED          = 3,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 200_000_000,
  parameter int unsigned PWM_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic             period_load,
  input  logic [PWM_W-1:0] duty,
  output logic [N_LED-1:0] led,
  output logic [N_LED-1:0] pattern,
  output logic             step_pulse
);

  localparam logic [CNT_W-1:0] RST_PERIOD =
    (DEFAULT_PERIOD == 0) ? CNT_W'(1) : CNT_W'(DEFAULT_PERIOD);
  localparam logic [N_LED-1:0] PAT_ONE = N_LED'(1);

  logic [1:0]       mode_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] cnt;
  logic             dir;
  logic             gate;

  logic             mode_chg_c;
  logic             step_c;
  pat_step_t        step_res_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic [N_LED-1:0] pat_nxt_c;
  logic             dir_nxt_c;
  logic             unused_pat_hi_c;

  led_pwm #(.PWM_W(PWM_W)) u_pwm (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .duty   (duty),
    .gate   (gate)
  );

  // Step timing, mode-change restart and next pattern/direction selection.
  always_comb begin
    mode_chg_c = (mode != mode_reg);
    step_c     = enable && (cnt == period_reg - CNT_W'(1)) && !mode_chg_c;
    step_res_c = next_pattern(mode_reg, PAT_MAX_W'(pattern), dir, N_LED);
    // Bits above N_LED are always zero after masking inside next_pattern.
    unused_pat_hi_c = ^step_res_c.pat;

    cnt_nxt_c = cnt;
    if (mode_chg_c || period_load) cnt_nxt_c = '0;
    else if (enable)               cnt_nxt_c = (cnt == period_reg - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);

    pat_nxt_c = pattern;
    dir_nxt_c = dir;
    if (mode_chg_c) begin
      pat_nxt_c = PAT_ONE;
      dir_nxt_c = DIR_UP;
    end else if (step_c) begin
      pat_nxt_c = step_res_c.pat[N_LED-1:0];
      dir_nxt_c = step_res_c.dir;
    end
  end

  // State and output registers; led tracks the pattern being loaded this cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_reg   <= MODE_ROT_L;
      period_reg <= RST_PERIOD;
      cnt        <= '0;
      dir        <= DIR_UP;
      pattern    <= PAT_ONE;
      led        <= '0;
      step_pulse <= 1'b0;
    end else begin
      mode_reg <= mode;
      if (period_load) period_reg <= (period == '0) ? CNT_W'(1) : period;
      cnt        <= cnt_nxt_c;
      dir        <= dir_nxt_c;
      pattern    <= pat_nxt_c;
      led        <= pat_nxt_c & {N_LED{gate}};
      step_pulse <= step_c;
    end
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have parameter N_LED, default 3: LED output width; legal values 2..32.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of the step-period counter.
REQ-003 The block SHALL have parameter DEFAULT_PERIOD, default 200_000_000: period in clk cycles after reset.
REQ-004 The block SHALL have parameter PWM_W, default 8: width of the brightness duty and PWM counter.
REQ-005 The block SHALL have the following ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- enable  in  1  run when high, freeze when low
- mode  in  2  pattern mode
- period  in  CNT_W  new step period in clk cycles
- period_load  in  1  one-cycle strobe; captures period
- duty  in  PWM_W  brightness
- led  out  N_LED  PWM-gated pattern
- pattern  out  N_LED  ungated pattern
- step_pulse  out  1  one-cycle pulse on every pattern step

Function
REQ-006 The block SHALL hold an internal period_reg; period_load=1 captures period, and a captured value of 0 SHALL be stored as 1.
REQ-007 The period counter SHALL count 0..period_reg-1 while enable=1 and hold while enable=0; a step SHALL occur in the cycle the counter equals period_reg-1, and the counter SHALL return to 0.
REQ-008 On period_load the period counter SHALL clear to 0; a load coincident with a step SHALL still produce that step.
REQ-009 step_pulse SHALL be high for exactly the one cycle after each step, when the updated pattern first appears.
REQ-010 Mode 0 (rotate left) SHALL advance the pattern as {p[N-2:0], p[N-1]}.
REQ-011 Mode 1 (rotate right) SHALL advance the pattern as {p[0], p[N-1:1]}.
REQ-012 Mode 2 (bounce) SHALL move a single hot bit using a direction flag:
- moving up, it shifts left; on reaching bit N-1 the flag flips to down;
- moving down, it shifts right; on reaching bit 0 the flag flips to up;
- for N_LED=3 the sequence SHALL be 001,010,100,010,001,010,...
REQ-013 Mode 3 (count) SHALL advance the pattern as p+1 modulo 2^N_LED, wrapping all-ones to 0.
REQ-014 mode SHALL be registered each cycle; a change of the registered mode SHALL do all of the following:
- set the pattern to 1;
- set the direction flag to up;
- clear the period counter;
- suppress any step in that cycle.
REQ-015 PWM SHALL use a free-running PWM_W counter with enable=1 and hold it with enable=0.
REQ-016 The PWM gate SHALL be on when pwm_cnt < duty, and always on when duty is all-ones.
REQ-017 led SHALL equal pattern AND the replicated gate; duty=0 SHALL force led to 0.
REQ-018 The outputs led and pattern SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-019 While resetn=0 at a clk edge, the following SHALL be forced:
- pattern to 1 and led to 0;
- step_pulse to 0;
- period_reg to DEFAULT_PERIOD (or 1 if DEFAULT_PERIOD is 0);
- the period counter and pwm_cnt to 0;
- the direction flag to up;
- the registered mode to 0.
REQ-020 A reset asserted mid-step or mid-bounce SHALL discard all progress, and the first step after release SHALL occur period_reg cycles after release with enable=1.

Structure
REQ-021 A shared package led_seq_pkg SHALL hold:
- the mode constants MODE_ROT_L=0, MODE_ROT_R=1, MODE_BOUNCE=2, MODE_COUNT=3;
- a function computing the next pattern from (mode, pattern, dir).
REQ-022 A sub-module led_pwm (PWM counter plus comparator; parameter PWM_W; ports clk, resetn, enable, duty, gate) SHALL generate the gate.

Verification
REQ-023 The bench SHALL cover: N_LED=3, period_load 4, mode 0, duty all-ones -> pattern 001,010,100,001 every 4 cycles, with one step_pulse per step.
REQ-024 The bench SHALL cover: mode 2, period 1 -> pattern 001,010,100,010,001 on consecutive cycles.
REQ-025 The bench SHALL cover: mode 3, period 2, N_LED=3 -> pattern counts 1..7, then 0, then 1; the wrap is observed.
REQ-026 The bench SHALL cover: period_load 0 -> the block behaves as period 1; enable low for 10 cycles -> pattern, counter and step_pulse frozen.
REQ-027 The bench SHALL cover: PWM_W=4 with duty 0, 8 and 15 -> led high for 0/16, 8/16 and 16/16 cycles of the PWM period respectively.
REQ-028 The bench SHALL cover: a mode change from 2 to 1 mid-bounce at pattern 100 -> pattern 001 the next cycle, then 100 after one period; resetn pulsed mid-run -> all reset values per REQ-019.
